// File: rtl/shutter_nuc_ctrl.sv
// Shutter / NUC calibration sequencer.
// Decides when to recalibrate (power-on, manual, temperature drift, frame
// interval), then closes the shutter, lets it settle, starts the background
// calculation, reopens the shutter and lets it settle again.
module shutter_nuc_ctrl #(
    parameter logic [1:0]  SHUTTER_OPEN  = 2'b01,
    parameter logic [1:0]  SHUTTER_CLOS  = 2'b10,
    parameter int unsigned SETTLE_FRAMES = 4,
    parameter int unsigned CALC_TIMEOUT  = 8,
    parameter logic [15:0] TEMP_DELTA    = 16'd64,
    parameter logic [15:0] MAX_INTERVAL  = 16'd1800
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_frame_start,
    input  logic        i_manual_req,
    input  logic [15:0] i_temp_sensor,
    input  logic        i_calc_b_done,
    output logic [1:0]  o_shutter,
    output logic        o_calc_b_start,
    output logic        o_busy,
    output logic [1:0]  o_cause,
    output logic [7:0]  o_nuc_cnt,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLOSE, S_SETTLE_C, S_CALC, S_OPEN, S_SETTLE_O
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
    localparam logic [7:0] CALC_LAST   = 8'(CALC_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  frm_cnt_q, frm_cnt_d;
    logic [15:0] int_cnt_q, int_cnt_d;
    logic [15:0] ref_temp_q, ref_temp_d;
    logic        ref_valid_q, ref_valid_d;
    logic        pend_pwr_q, pend_pwr_d;
    logic        pend_man_q, pend_man_d;
    logic [1:0]  shutter_q, shutter_d;
    logic        calc_start_q, calc_start_d;
    logic        busy_q, busy_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  nuc_cnt_q, nuc_cnt_d;
    logic        err_q, err_d;

    logic [16:0] temp_ext, ref_ext, abs_diff;
    logic        drift, interval, man_now;

    // Trigger conditions: 17-bit absolute temperature difference and frame interval.
    always_comb begin
        temp_ext = {1'b0, i_temp_sensor};
        ref_ext  = {1'b0, ref_temp_q};
        abs_diff = (temp_ext >= ref_ext) ? (temp_ext - ref_ext) : (ref_ext - temp_ext);
        drift    = ref_valid_q && (abs_diff >= {1'b0, TEMP_DELTA});
        interval = (int_cnt_q >= MAX_INTERVAL);
        man_now  = pend_man_q | i_manual_req;
    end

    // Next-state and registered-output logic of the calibration sequencer.
    always_comb begin
        state_d      = state_q;
        frm_cnt_d    = frm_cnt_q;
        int_cnt_d    = int_cnt_q;
        ref_temp_d   = ref_temp_q;
        ref_valid_d  = ref_valid_q;
        pend_pwr_d   = pend_pwr_q;
        pend_man_d   = man_now;
        shutter_d    = 2'b00;
        calc_start_d = 1'b0;
        busy_d       = busy_q;
        cause_d      = cause_q;
        nuc_cnt_d    = nuc_cnt_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_frame_start && (int_cnt_q != '1)) int_cnt_d = int_cnt_q + 16'd1;
                if (i_en && (pend_pwr_q || man_now || drift || interval)) begin
                    state_d   = S_CLOSE;
                    shutter_d = SHUTTER_CLOS;
                    busy_d    = 1'b1;
                    frm_cnt_d = '0;
                    if (pend_pwr_q) begin
                        cause_d    = 2'd0;
                        pend_pwr_d = 1'b0;
                    end else if (man_now) begin
                        cause_d    = 2'd1;
                        pend_man_d = 1'b0;
                    end else if (drift) begin
                        cause_d = 2'd2;
                    end else begin
                        cause_d = 2'd3;
                    end
                end
            end
            S_CLOSE: begin
                state_d   = S_SETTLE_C;
                frm_cnt_d = '0;
            end
            S_SETTLE_C: begin
                if (i_frame_start) begin
                    if (frm_cnt_q == SETTLE_LAST) begin
                        state_d      = S_CALC;
                        calc_start_d = 1'b1;
                        frm_cnt_d    = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 8'd1;
                    end
                end
            end
            S_CALC: begin
                // Done takes priority over a timeout completing on the same cycle.
                if (i_calc_b_done) begin
                    ref_temp_d  = i_temp_sensor;
                    ref_valid_d = 1'b1;
                    if (nuc_cnt_q != '1) nuc_cnt_d = nuc_cnt_q + 8'd1;
                    state_d   = S_OPEN;
                    shutter_d = SHUTTER_OPEN;
                    frm_cnt_d = '0;
                end else if (i_frame_start) begin
                    if (frm_cnt_q == CALC_LAST) begin
                        err_d     = 1'b1;
                        state_d   = S_OPEN;
                        shutter_d = SHUTTER_OPEN;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 8'd1;
                    end
                end
            end
            S_OPEN: begin
                state_d   = S_SETTLE_O;
                frm_cnt_d = '0;
            end
            S_SETTLE_O: begin
                if (i_frame_start) begin
                    if (frm_cnt_q == SETTLE_LAST) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        int_cnt_d = '0;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            frm_cnt_q    <= '0;
            int_cnt_q    <= '0;
            ref_temp_q   <= '0;
            ref_valid_q  <= 1'b0;
            pend_pwr_q   <= 1'b1;
            pend_man_q   <= 1'b0;
            shutter_q    <= '0;
            calc_start_q <= 1'b0;
            busy_q       <= 1'b0;
            cause_q      <= '0;
            nuc_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frm_cnt_q    <= frm_cnt_d;
            int_cnt_q    <= int_cnt_d;
            ref_temp_q   <= ref_temp_d;
            ref_valid_q  <= ref_valid_d;
            pend_pwr_q   <= pend_pwr_d;
            pend_man_q   <= pend_man_d;
            shutter_q    <= shutter_d;
            calc_start_q <= calc_start_d;
            busy_q       <= busy_d;
            cause_q      <= cause_d;
            nuc_cnt_q    <= nuc_cnt_d;
            err_q        <= err_d;
        end
    end

    assign o_shutter      = shutter_q;
    assign o_calc_b_start = calc_start_q;
    assign o_busy         = busy_q;
    assign o_cause        = cause_q;
    assign o_nuc_cnt      = nuc_cnt_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_shutter_nuc_ctrl.sv
// Directed testbench for shutter_nuc_ctrl (interval shortened to 10 frames).
module tb_shutter_nuc_ctrl;

    localparam int FRAME_GAP = 6;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_manual_req = 1'b0;
    logic [15:0] i_temp_sensor = 16'd1000;
    logic        i_calc_b_done = 1'b0;
    logic [1:0]  o_shutter;
    logic        o_calc_b_start;
    logic        o_busy;
    logic [1:0]  o_cause;
    logic [7:0]  o_nuc_cnt;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_clos  = 0;
    int n_open  = 0;
    int n_start = 0;
    int c0, o0, s0;

    shutter_nuc_ctrl #(.MAX_INTERVAL(16'd10)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_frame_start(i_frame_start),
        .i_manual_req(i_manual_req), .i_temp_sensor(i_temp_sensor),
        .i_calc_b_done(i_calc_b_done), .o_shutter(o_shutter),
        .o_calc_b_start(o_calc_b_start), .o_busy(o_busy), .o_cause(o_cause),
        .o_nuc_cnt(o_nuc_cnt), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // Count command cycles on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (o_shutter == 2'b10) n_clos++;
        if (o_shutter == 2'b01) n_open++;
        if (o_calc_b_start) n_start++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Each frame: idle gap, then a one-cycle pulse; returns just after the pulse edge.
    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (FRAME_GAP - 1) tick();
            i_frame_start = 1'b1;
            tick();
            i_frame_start = 1'b0;
        end
    endtask

    // Drives a sequence from its CLOSE cycle back to IDLE.
    task automatic finish_seq(input bit give_done);
        tick();
        frames(4);
        if (give_done) begin
            repeat (5) tick();
            i_calc_b_done = 1'b1;
            tick();
            i_calc_b_done = 1'b0;
        end else begin
            frames(8);
        end
        tick();
        frames(4);
    endtask

    task automatic test_reset();
        i_en = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({o_shutter, o_calc_b_start, o_busy, o_cause, o_nuc_cnt, o_err} !== 15'd0) begin
            $display("FAIL reset_outputs: got sh=%b st=%b busy=%b cause=%0d nuc=%0d err=%b want all 0",
                     o_shutter, o_calc_b_start, o_busy, o_cause, o_nuc_cnt, o_err);
            n_fail++;
        end
    endtask

    task automatic test_power_on();
        c0 = n_clos; o0 = n_open; s0 = n_start;
        i_rst = 1'b0;
        tick();
        n_tests++; if (o_shutter !== 2'b10) begin $display("FAIL po_close: got %b want 10", o_shutter); n_fail++; end
        n_tests++; if (o_busy !== 1'b1 || o_cause !== 2'd0) begin $display("FAIL po_busy_cause: got busy=%b cause=%0d want 1/0", o_busy, o_cause); n_fail++; end
        tick();
        n_tests++; if (o_shutter !== 2'b00) begin $display("FAIL po_close_len: got %b want 00", o_shutter); n_fail++; end
        frames(3);
        n_tests++; if (o_calc_b_start !== 1'b0) begin $display("FAIL po_start_early: got %b want 0", o_calc_b_start); n_fail++; end
        frames(1);
        n_tests++; if (o_calc_b_start !== 1'b1) begin $display("FAIL po_start: got %b want 1", o_calc_b_start); n_fail++; end
        tick();
        n_tests++; if (o_calc_b_start !== 1'b0) begin $display("FAIL po_start_len: got %b want 0", o_calc_b_start); n_fail++; end
        repeat (4) tick();
        i_calc_b_done = 1'b1;
        tick();
        i_calc_b_done = 1'b0;
        n_tests++; if (o_shutter !== 2'b01 || o_nuc_cnt !== 8'd1) begin $display("FAIL po_open: got sh=%b nuc=%0d want 01/1", o_shutter, o_nuc_cnt); n_fail++; end
        tick();
        n_tests++; if (o_shutter !== 2'b00) begin $display("FAIL po_open_len: got %b want 00", o_shutter); n_fail++; end
        frames(3);
        n_tests++; if (o_busy !== 1'b1) begin $display("FAIL po_settle_o: got busy=%b want 1", o_busy); n_fail++; end
        frames(1);
        n_tests++; if (o_busy !== 1'b0 || o_err !== 1'b0 || o_cause !== 2'd0) begin $display("FAIL po_idle: got busy=%b err=%b cause=%0d want 0/0/0", o_busy, o_err, o_cause); n_fail++; end
        n_tests++; if (n_clos - c0 != 1 || n_open - o0 != 1 || n_start - s0 != 1) begin $display("FAIL po_pulse_counts: got clos=%0d open=%0d start=%0d want 1/1/1", n_clos - c0, n_open - o0, n_start - s0); n_fail++; end
    endtask

    task automatic test_drift();
        i_calc_b_done = 1'b1;
        tick();
        i_calc_b_done = 1'b0;
        n_tests++; if (o_nuc_cnt !== 8'd1 || o_busy !== 1'b0) begin $display("FAIL done_outside_calc: got nuc=%0d busy=%b want 1/0", o_nuc_cnt, o_busy); n_fail++; end
        i_temp_sensor = 16'd1063;
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0) begin $display("FAIL drift_63_up: got busy=%b want 0", o_busy); n_fail++; end
        i_temp_sensor = 16'd1064;
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd2) begin $display("FAIL drift_64_up: got sh=%b cause=%0d want 10/2", o_shutter, o_cause); n_fail++; end
        i_temp_sensor = 16'd1000;
        finish_seq(1'b1);
        n_tests++; if (o_busy !== 1'b0 || o_nuc_cnt !== 8'd2) begin $display("FAIL drift_seq_end: got busy=%b nuc=%0d want 0/2", o_busy, o_nuc_cnt); n_fail++; end
        i_temp_sensor = 16'd937;
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0) begin $display("FAIL drift_63_down: got busy=%b want 0", o_busy); n_fail++; end
        i_temp_sensor = 16'd936;
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd2) begin $display("FAIL drift_64_down: got sh=%b cause=%0d want 10/2", o_shutter, o_cause); n_fail++; end
        i_temp_sensor = 16'd1000;
        finish_seq(1'b1);
        n_tests++; if (o_nuc_cnt !== 8'd3) begin $display("FAIL drift_down_end: got nuc=%0d want 3", o_nuc_cnt); n_fail++; end
    endtask

    task automatic test_manual_vs_drift();
        i_temp_sensor = 16'd1100;
        i_manual_req = 1'b1;
        tick();
        i_manual_req = 1'b0;
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd1) begin $display("FAIL man_beats_drift: got sh=%b cause=%0d want 10/1", o_shutter, o_cause); n_fail++; end
        i_temp_sensor = 16'd1000;
        finish_seq(1'b1);
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0 || o_nuc_cnt !== 8'd4) begin $display("FAIL man_not_pending: got busy=%b nuc=%0d want 0/4", o_busy, o_nuc_cnt); n_fail++; end
    endtask

    task automatic test_manual_pending();
        c0 = n_clos;
        i_manual_req = 1'b1;
        tick();
        i_manual_req = 1'b0;
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd1) begin $display("FAIL man_start: got sh=%b cause=%0d want 10/1", o_shutter, o_cause); n_fail++; end
        tick();
        i_manual_req = 1'b1; tick(); i_manual_req = 1'b0; tick();
        i_manual_req = 1'b1; tick(); i_manual_req = 1'b0;
        finish_seq(1'b1);
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd1) begin $display("FAIL man_pending_start: got sh=%b cause=%0d want 10/1", o_shutter, o_cause); n_fail++; end
        finish_seq(1'b1);
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0 || o_nuc_cnt !== 8'd6 || n_clos - c0 != 2) begin $display("FAIL man_merge: got busy=%b nuc=%0d seqs=%0d want 0/6/2", o_busy, o_nuc_cnt, n_clos - c0); n_fail++; end
    endtask

    task automatic test_timeout();
        o0 = n_open;
        frames(5);
        i_manual_req = 1'b1;
        tick();
        i_manual_req = 1'b0;
        i_temp_sensor = 16'd500;
        finish_seq(1'b0);
        i_temp_sensor = 16'd1063;
        n_tests++; if (o_err !== 1'b1 || o_nuc_cnt !== 8'd6 || o_busy !== 1'b0) begin $display("FAIL timeout_end: got err=%b nuc=%0d busy=%b want 1/6/0", o_err, o_nuc_cnt, o_busy); n_fail++; end
        n_tests++; if (n_open - o0 != 1) begin $display("FAIL timeout_open: got %0d open pulses want 1", n_open - o0); n_fail++; end
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0) begin $display("FAIL timeout_ref_kept: got busy=%b want 0", o_busy); n_fail++; end
        i_temp_sensor = 16'd1000;
    endtask

    task automatic test_interval();
        frames(9);
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0) begin $display("FAIL interval_9: got busy=%b want 0", o_busy); n_fail++; end
        frames(1);
        n_tests++; if (o_busy !== 1'b0 || o_shutter !== 2'b00) begin $display("FAIL interval_10_edge: got busy=%b sh=%b want 0/00", o_busy, o_shutter); n_fail++; end
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd3) begin $display("FAIL interval_start: got sh=%b cause=%0d want 10/3", o_shutter, o_cause); n_fail++; end
        finish_seq(1'b1);
        n_tests++; if (o_nuc_cnt !== 8'd7 || o_err !== 1'b1) begin $display("FAIL interval_end: got nuc=%0d err=%b want 7/1", o_nuc_cnt, o_err); n_fail++; end
        i_en = 1'b0;
        frames(10);
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0) begin $display("FAIL en_low_hold: got busy=%b want 0", o_busy); n_fail++; end
        i_en = 1'b1;
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd3) begin $display("FAIL en_raise_start: got sh=%b cause=%0d want 10/3", o_shutter, o_cause); n_fail++; end
    endtask

    task automatic test_reset_mid();
        tick();
        frames(4);
        repeat (2) tick();
        #2 i_rst = 1'b1;
        #1;
        n_tests++; if ({o_shutter, o_busy, o_nuc_cnt, o_err, o_cause} !== 14'd0) begin $display("FAIL async_rst_calc: got sh=%b busy=%b nuc=%0d err=%b cause=%0d want all 0", o_shutter, o_busy, o_nuc_cnt, o_err, o_cause); n_fail++; end
        #1 i_rst = 1'b0;
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd0) begin $display("FAIL rst_po_restart: got sh=%b cause=%0d want 10/0", o_shutter, o_cause); n_fail++; end
        #2 i_rst = 1'b1;
        #1;
        n_tests++; if (o_shutter !== 2'b00 || o_busy !== 1'b0) begin $display("FAIL async_rst_close: got sh=%b busy=%b want 00/0", o_shutter, o_busy); n_fail++; end
        #1 i_rst = 1'b0;
        tick();
        n_tests++; if (o_shutter !== 2'b10 || o_cause !== 2'd0) begin $display("FAIL rst_po_again: got sh=%b cause=%0d want 10/0", o_shutter, o_cause); n_fail++; end
        finish_seq(1'b1);
        n_tests++; if (o_nuc_cnt !== 8'd1 || o_busy !== 1'b0 || o_err !== 1'b0) begin $display("FAIL rst_po_end: got nuc=%0d busy=%b err=%b want 1/0/0", o_nuc_cnt, o_busy, o_err); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_drift();
        test_manual_vs_drift();
        test_manual_pending();
        test_timeout();
        test_interval();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
